// File: rtl/uci_tx_arbiter.sv
// uci_tx_arbiter: round-robin, line-atomic sharing of one UCI TX byte stream among NUM_REQ producers.
// Optional line-length guard enabled by defining UCI_TX_ARB_LINE_GUARD_EN.

module uci_tx_arb_lane (
    input  logic       stream_ok,
    input  logic       grant,
    input  logic       valid,
    input  logic [7:0] chr,
    output logic       ready,
    output logic       take,
    output logic [7:0] char_sel
);
    assign ready    = stream_ok & grant;
    assign take     = ready & valid;
    assign char_sel = take ? chr : 8'h00;
endmodule

module uci_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int MAX_LINE_LEN = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0][7:0] req_char_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    output logic [7:0]              char_out,
    output logic                    char_out_valid,
    input  logic                    char_out_ready,
    output logic [NUM_REQ-1:0]      grant_out,
    output logic                    busy_out
);
    localparam int         PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] NL = 8'h0A;

    if (NUM_REQ < 2 || MAX_LINE_LEN < 2 || MAX_LINE_LEN > 128) begin : g_param_chk
        $error("uci_tx_arbiter: NUM_REQ must be >= 2 and MAX_LINE_LEN in 2..128");
    end

    typedef enum logic [1:0] {IDLE, STREAM, INJECT} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [7:0]         char_d;
    logic               valid_d;

    logic                    out_empty;
    logic                    stream_ok;
    logic                    accept;
    logic [NUM_REQ-1:0]      take;
    logic [NUM_REQ-1:0][7:0] char_sel;
    logic [7:0]              acc_char;

    logic [PW-1:0] win;
    logic [PW-1:0] idx_w;
    logic          found;
    int            arb_idx;

`ifdef UCI_TX_ARB_LINE_GUARD_EN
    logic [6:0] cnt_q, cnt_d;
`endif

    // Output register can take a new byte when empty or draining this cycle.
    assign out_empty = ~char_out_valid | char_out_ready;
    assign stream_ok = (state_q == STREAM) & out_empty;
    assign busy_out  = (state_q != IDLE) | char_out_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        uci_tx_arb_lane u_lane (
            .stream_ok (stream_ok),
            .grant     (grant_out[g]),
            .valid     (req_valid_in[g]),
            .chr       (req_char_in[g]),
            .ready     (req_ready_out[g]),
            .take      (take[g]),
            .char_sel  (char_sel[g])
        );
    end

    always_comb begin
        acc_char = '0;
        for (int i = 0; i < NUM_REQ; i++) acc_char = acc_char | char_sel[i];
    end
    assign accept = |take;

    // Round-robin search beginning at ptr_q.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        arb_idx = 0;
        idx_w   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            idx_w = PW'(arb_idx);
            if (!found && req_valid_in[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_out;
        char_d  = char_out;
        valid_d = char_out_valid & ~char_out_ready;
`ifdef UCI_TX_ARB_LINE_GUARD_EN
        cnt_d   = cnt_q;
`endif
        if (accept) begin
            char_d  = acc_char;
            valid_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = STREAM;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    ptr_d        = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (acc_char == NL) begin
                        state_d = IDLE;
                        grant_d = '0;
`ifdef UCI_TX_ARB_LINE_GUARD_EN
                        cnt_d   = '0;
`endif
                    end
`ifdef UCI_TX_ARB_LINE_GUARD_EN
                    // Leave room for the forced newline so the line fits MAX_LINE_LEN.
                    else if (int'(cnt_q) + 1 >= MAX_LINE_LEN - 1) begin
                        state_d = INJECT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
`endif
                end
            end
`ifdef UCI_TX_ARB_LINE_GUARD_EN
            INJECT: begin
                if (out_empty) begin
                    char_d  = NL;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            grant_out      <= '0;
            char_out       <= '0;
            char_out_valid <= 1'b0;
`ifdef UCI_TX_ARB_LINE_GUARD_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_out      <= grant_d;
            char_out       <= char_d;
            char_out_valid <= valid_d;
`ifdef UCI_TX_ARB_LINE_GUARD_EN
            cnt_q          <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_uci_tx_arbiter.sv
// Directed bench for uci_tx_arbiter: a per-cycle vector table plus producer/sink driven line sequences.
module tb_uci_tx_arbiter;
`ifdef UCI_TX_ARB_LINE_GUARD_EN
    localparam int MLL = 8;
`else
    localparam int MLL = 64;
`endif

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [2:0][7:0] req_char_in;
    logic [2:0]      req_valid_in;
    logic [2:0]      req_ready_out;
    logic [7:0]      char_out;
    logic            char_out_valid;
    logic            char_out_ready;
    logic [2:0]      grant_out;
    logic            busy_out;

    uci_tx_arbiter #(.NUM_REQ(3), .MAX_LINE_LEN(MLL)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_char_in    (req_char_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .char_out       (char_out),
        .char_out_valid (char_out_valid),
        .char_out_ready (char_out_ready),
        .grant_out      (grant_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] vld;
        logic [7:0] ch;
        logic       ordy;
        logic [2:0] e_grant;
        logic [2:0] e_rdy;
        logic       e_cv;
        logic [7:0] e_co;
        logic       e_busy;
    } vec_t;

    vec_t tbl[12];

    int total = 0;
    int bad   = 0;

    string      line[3];
    int         pos[3];
    logic [2:0] hold;
    logic       sink_rdy;
    string      got;
    int         cyc, t_first_acc, t_first_cv, t_last_acc;
    logic [2:0] first_grant;
    int         gbad, stall_bad, hold_bad;
    logic [7:0] held;
    bit         stall_seen;
    int         stall_lo, stall_hi, hold_lo, hold_hi, hold_req;

    function automatic vec_t mk(input logic [2:0] vld, input logic [7:0] ch, input logic ordy,
                                input logic [2:0] g, input logic [2:0] r, input logic cv,
                                input logic [7:0] co, input logic busy);
        vec_t v;
        v.vld = vld; v.ch = ch; v.ordy = ordy;
        v.e_grant = g; v.e_rdy = r; v.e_cv = cv; v.e_co = co; v.e_busy = busy;
        return v;
    endfunction

    function automatic string vis(input string s);
        string o;
        o = "";
        for (int i = 0; i < s.len(); i++)
            o = (s[i] == 8'h0A) ? {o, "|"} : $sformatf("%s%c", o, s[i]);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, vis(act), vis(exp));
        end
    endtask

    task automatic clear_book();
        for (int i = 0; i < 3; i++) begin
            line[i] = "";
            pos[i]  = 0;
        end
        hold = '0; sink_rdy = 1'b1; got = ""; cyc = 0;
        t_first_acc = -1; t_first_cv = -1; t_last_acc = -1; first_grant = '0;
        gbad = 0; stall_bad = 0; hold_bad = 0; held = '0; stall_seen = 0;
        stall_lo = 1000; stall_hi = -1; hold_lo = 1000; hold_hi = -1; hold_req = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk_in);
        rst_in = 1'b1;
        req_valid_in = '0;
        req_char_in = '0;
        char_out_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        clear_book();
        rst_in = 1'b0;
    endtask

    task automatic step();
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            req_valid_in[i] = (pos[i] < line[i].len()) && !hold[i];
            req_char_in[i]  = req_valid_in[i] ? line[i][pos[i]] : 8'h00;
        end
        char_out_ready = sink_rdy;
        #1;
        if (char_out_valid && char_out_ready) got = $sformatf("%s%c", got, char_out);
        if (first_grant == 3'b000) first_grant = grant_out;
        if (char_out_valid && t_first_cv < 0) t_first_cv = cyc;
        if (!sink_rdy) begin
            if (!stall_seen) begin
                held = char_out;
                stall_seen = 1;
            end
            if (req_ready_out != 3'b000 || !char_out_valid || char_out != held) stall_bad++;
        end
        if (hold != 3'b000 && grant_out != (3'b001 << hold_req)) hold_bad++;
        for (int i = 0; i < 3; i++) begin
            if (req_valid_in[i] && req_ready_out[i]) begin
                pos[i]++;
                if (t_first_acc < 0) t_first_acc = cyc;
                t_last_acc = cyc;
                if (grant_out != (3'b001 << i)) gbad++;
            end
        end
        cyc++;
    endtask

    task automatic run_lines(input string name, input string exp, input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            sink_rdy = !(n >= stall_lo && n <= stall_hi);
            hold = '0;
            if (n >= hold_lo && n <= hold_hi) hold[hold_req] = 1'b1;
            step();
            n++;
            done = (pos[0] == line[0].len()) && (pos[1] == line[1].len()) &&
                   (pos[2] == line[2].len()) && !busy_out;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk_s({name, "_stream"}, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] act, exp;

        tbl[0]  = mk(3'b000, 8'h00, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        tbl[1]  = mk(3'b110, "x",   1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        tbl[2]  = mk(3'b110, "P",   1'b1, 3'b010, 3'b010, 1'b0, 8'h00, 1'b1);
        tbl[3]  = mk(3'b110, "Q",   1'b0, 3'b010, 3'b000, 1'b1, "P",   1'b1);
        tbl[4]  = mk(3'b110, 8'h0A, 1'b1, 3'b010, 3'b010, 1'b1, "P",   1'b1);
        tbl[5]  = mk(3'b100, "R",   1'b1, 3'b000, 3'b000, 1'b1, 8'h0A, 1'b1);
        tbl[6]  = mk(3'b101, 8'h0A, 1'b1, 3'b100, 3'b100, 1'b0, 8'h00, 1'b1);
        tbl[7]  = mk(3'b001, "S",   1'b0, 3'b000, 3'b000, 1'b1, 8'h0A, 1'b1);
        tbl[8]  = mk(3'b001, "T",   1'b0, 3'b001, 3'b000, 1'b1, 8'h0A, 1'b1);
        tbl[9]  = mk(3'b001, "T",   1'b1, 3'b001, 3'b001, 1'b1, 8'h0A, 1'b1);
        tbl[10] = mk(3'b000, 8'h00, 1'b1, 3'b001, 3'b001, 1'b1, "T",   1'b1);
        tbl[11] = mk(3'b000, 8'h00, 1'b1, 3'b001, 3'b001, 1'b0, 8'h00, 1'b1);

        clear_book();
        rst_in = 1'b1;
        req_valid_in = '0;
        req_char_in = '0;
        char_out_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        // {grant, ready, valid, busy, char (only when valid expected)}
        for (int r = 0; r < 12; r++) begin
            @(negedge clk_in);
            req_valid_in = tbl[r].vld;
            for (int i = 0; i < 3; i++) req_char_in[i] = tbl[r].ch;
            char_out_ready = tbl[r].ordy;
            #1;
            act = {16'h0, grant_out, req_ready_out, char_out_valid, busy_out,
                   (tbl[r].e_cv ? char_out : 8'h00)};
            exp = {16'h0, tbl[r].e_grant, tbl[r].e_rdy, tbl[r].e_cv, tbl[r].e_busy,
                   (tbl[r].e_cv ? tbl[r].e_co : 8'h00)};
            chk($sformatf("vec%0d", r), act, exp);
        end

        // Async reset mid-line with a byte held in the output register.
        @(negedge clk_in);
        req_valid_in = 3'b001;
        req_char_in[0] = "U";
        char_out_ready = 1'b0;
        @(negedge clk_in);
        chk("pre_reset_valid", {23'h0, char_out_valid, char_out}, {23'h0, 1'b1, 8'h55});
        #2 rst_in = 1'b1;
        #1;
        chk("async_reset", {16'h0, grant_out, req_ready_out, char_out_valid, busy_out, char_out},
            32'h0);
        repeat (3) @(negedge clk_in);
        clear_book();
        line[0] = "a\na\n";
        line[1] = "b\n";
        line[2] = "c\n";
        rst_in = 1'b0;
        run_lines("round_robin", "a\nb\nc\na\n", 200);
        chk("first_grant", 32'(first_grant), 32'b001);
        chk("rr_grant_on_accept", gbad, 0);

`ifndef UCI_TX_ARB_LINE_GUARD_EN
        reset_dut();
        line[1] = "bestmove e2e4\n";
        run_lines("single_line", "bestmove e2e4\n", 200);
        chk("single_grant_010", gbad, 0);
        chk("single_latency", t_first_cv - t_first_acc, 1);
        chk("single_consecutive", t_last_acc - t_first_acc, 13);
        chk("single_grant_release", 32'(grant_out), 32'b000);
`endif

        reset_dut();
        line[0] = "abcdef\n";
        stall_lo = 4;
        stall_hi = 8;
        run_lines("backpressure", "abcdef\n", 200);
        chk("bp_stall_stable", stall_bad, 0);
        chk("bp_stall_seen", 32'(stall_seen), 32'd1);

        reset_dut();
        line[0] = "abcdef\n";
        line[1] = "xy\n";
        hold_req = 0;
        hold_lo = 3;
        hold_hi = 6;
        run_lines("gap", "abcdef\nxy\n", 200);
        chk("gap_grant_held", hold_bad, 0);

`ifdef UCI_TX_ARB_LINE_GUARD_EN
        reset_dut();
        line[2] = "0123456789A\n";
        run_lines("guard", "0123456\n789A\n", 200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
